// File: rtl/fp_mul.sv
// fp_mul: sequential IEEE-754 single-precision multiplier.
// The 24x24 significand product is built by a radix-2 shift-and-add loop,
// one multiplier bit per cycle. Normalisation, five-mode rounding and the
// exception flags follow. The port shape matches fp_div so that the FPU top
// level can mux results and flags directly.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   act      - start request, sampled only in IDLE
//   in1/in2  - multiplicand / multiplier (W bits)
//   round_m  - rounding mode, sampled with act
//   out      - registered result, held until the next result
//   ov/un    - overflow / underflow
//   done     - one-cycle result-valid pulse
//   inv      - invalid operation
//   div_zero - always 0, kept for mux compatibility with fp_div
//   inexact  - the rounded result differs from the exact product
`timescale 1ns/1ps

module fp_mul #(
    parameter int W = 32,
    parameter int M = 22,
    parameter int E = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         act,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [2:0]   round_m,
    output logic [W-1:0] out,
    output logic         ov,
    output logic         un,
    output logic         done,
    output logic         inv,
    output logic         div_zero,
    output logic         inexact
);

    // Rounding-mode encodings (RNe, RZ, RD, RU, RNa).
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RZ  = 3'd1;
    localparam logic [2:0] RM_RD  = 3'd2;
    localparam logic [2:0] RM_RU  = 3'd3;
    localparam logic [2:0] RM_RNA = 3'd4;

    localparam logic [W-1:0] FP_NANQ = 32'h7FC0_0000;

    typedef enum logic [2:0] {S_IDLE, S_SPEC, S_MUL, S_NORM, S_RND} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [W-2:0]       r_op1;
    logic [W-2:0]       r_op2;
    logic               r_s;
    logic [2:0]         r_rm;
    logic [23:0]        r_a;
    logic [23:0]        r_b;
    logic [47:0]        r_acc;
    logic [4:0]         r_cnt;
    logic signed [9:0]  r_e;
    logic [M:0]         r_mant;
    logic               r_g;
    logic               r_st;

    // Operand classification (denormals count as zero).
    logic w_in_special;
    logic w_zero1, w_inf1, w_nan1, w_zero2, w_inf2, w_nan2;

    logic [W-1:0]       w_sp_out;
    logic               w_sp_inv;
    logic               w_inc;
    logic [32:0]        w_sum;
    logic signed [9:0]  w_e_fin;
    logic [W-1:0]       w_rn_out;
    logic               w_rn_ov;
    logic               w_rn_un;
    logic               w_rn_inx;

    assign w_in_special = (in1[E:M+1] == 8'd0) || (in1[E:M+1] == 8'hFF) ||
                          (in2[E:M+1] == 8'd0) || (in2[E:M+1] == 8'hFF);

    assign w_zero1 = (r_op1[E:M+1] == 8'd0);
    assign w_inf1  = (r_op1[E:M+1] == 8'hFF) && (r_op1[M:0] == 23'd0);
    assign w_nan1  = (r_op1[E:M+1] == 8'hFF) && (r_op1[M:0] != 23'd0);
    assign w_zero2 = (r_op2[E:M+1] == 8'd0);
    assign w_inf2  = (r_op2[E:M+1] == 8'hFF) && (r_op2[M:0] == 23'd0);
    assign w_nan2  = (r_op2[E:M+1] == 8'hFF) && (r_op2[M:0] != 23'd0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (act) begin
                    w_state_nxt = w_in_special ? S_SPEC : S_MUL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SPEC: w_state_nxt = S_IDLE;
            S_MUL: begin
                if (r_cnt == 5'd23) begin
                    w_state_nxt = S_NORM;
                end else begin
                    w_state_nxt = S_MUL;
                end
            end
            S_NORM:  w_state_nxt = S_RND;
            S_RND:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: special-case result and rounded result.
    always_comb begin
        w_sp_out = {r_s, 31'd0};
        w_sp_inv = 1'b0;
        if (w_nan1 || w_nan2) begin
            w_sp_out = FP_NANQ;
            w_sp_inv = 1'b1;
        end else if ((w_zero1 && w_inf2) || (w_inf1 && w_zero2)) begin
            w_sp_out = FP_NANQ;
            w_sp_inv = 1'b1;
        end else if (w_inf1 || w_inf2) begin
            w_sp_out = {r_s, 8'hFF, 23'd0};
        end else begin
            w_sp_out = {r_s, 31'd0};
        end

        case (r_rm)
            RM_RNE:  w_inc = r_g & (r_st | r_mant[0]);
            RM_RNA:  w_inc = r_g;
            RM_RZ:   w_inc = 1'b0;
            RM_RU:   w_inc = ~r_s & (r_g | r_st);
            RM_RD:   w_inc = r_s & (r_g | r_st);
            default: w_inc = r_g & (r_st | r_mant[0]);
        endcase

        // Exponent and mantissa incremented as one value so that a mantissa
        // carry rolls straight into the exponent.
        w_sum   = {r_e, r_mant} + {32'd0, w_inc};
        w_e_fin = w_sum[32:23];

        w_rn_ov  = 1'b0;
        w_rn_un  = 1'b0;
        w_rn_inx = r_g | r_st;
        w_rn_out = {r_s, w_e_fin[7:0], w_sum[M:0]};
        if (w_e_fin >= 10'sd255) begin
            w_rn_ov  = 1'b1;
            w_rn_inx = 1'b1;
            case (r_rm)
                RM_RZ:   w_rn_out = {r_s, 8'hFE, 23'h7FFFFF};
                RM_RU:   w_rn_out = r_s ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'd0};
                RM_RD:   w_rn_out = r_s ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7FFFFF};
                default: w_rn_out = {r_s, 8'hFF, 23'd0};
            endcase
        end else if (w_e_fin <= 10'sd0) begin
            w_rn_un  = 1'b1;
            w_rn_inx = 1'b1;
            w_rn_out = {r_s, 31'd0};
        end else begin
            w_rn_out = {r_s, w_e_fin[7:0], w_sum[M:0]};
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op1    <= 31'd0;
            r_op2    <= 31'd0;
            r_s      <= 1'b0;
            r_rm     <= 3'd0;
            r_a      <= 24'd0;
            r_b      <= 24'd0;
            r_acc    <= 48'd0;
            r_cnt    <= 5'd0;
            r_e      <= 10'sd0;
            r_mant   <= 23'd0;
            r_g      <= 1'b0;
            r_st     <= 1'b0;
            out      <= 32'd0;
            ov       <= 1'b0;
            un       <= 1'b0;
            done     <= 1'b0;
            inv      <= 1'b0;
            div_zero <= 1'b0;
            inexact  <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (act) begin
                        r_op1 <= in1[W-2:0];
                        r_op2 <= in2[W-2:0];
                        r_s   <= in1[W-1] ^ in2[W-1];
                        r_rm  <= round_m;
                        r_a   <= {1'b1, in1[M:0]};
                        r_b   <= {1'b1, in2[M:0]};
                        r_acc <= 48'd0;
                        r_cnt <= 5'd0;
                        r_e   <= $signed({2'b00, in1[E:M+1]}) + $signed({2'b00, in2[E:M+1]}) - 10'sd127;
                    end
                end
                S_SPEC: begin
                    out     <= w_sp_out;
                    inv     <= w_sp_inv;
                    ov      <= 1'b0;
                    un      <= 1'b0;
                    inexact <= 1'b0;
                    done    <= 1'b1;
                end
                S_MUL: begin
                    if (r_b[0]) begin
                        r_acc <= r_acc + ({24'd0, r_a} << r_cnt);
                    end
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    // Product of two [1,2) significands lies in [1,4).
                    if (r_acc[47]) begin
                        r_mant <= r_acc[46:24];
                        r_g    <= r_acc[23];
                        r_st   <= |r_acc[22:0];
                        r_e    <= r_e + 10'sd1;
                    end else begin
                        r_mant <= r_acc[45:23];
                        r_g    <= r_acc[22];
                        r_st   <= |r_acc[21:0];
                    end
                end
                S_RND: begin
                    out     <= w_rn_out;
                    ov      <= w_rn_ov;
                    un      <= w_rn_un;
                    inexact <= w_rn_inx;
                    inv     <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: scoreboard bench for fp_mul. The driver pushes the expected
// result, flags and latency when it issues an operation; an independent
// monitor pops and compares whenever done is high.
`timescale 1ns/1ps

module tb_fp_mul;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RZ  = 3'd1;
    localparam logic [2:0] RD  = 3'd2;
    localparam logic [2:0] RU  = 3'd3;
    localparam logic [2:0] RNA = 3'd4;

    // flags = {ov, un, inv, div_zero, inexact}
    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
        int          issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        act = 1'b0;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic [2:0]  round_m = 3'd0;
    logic [31:0] out;
    logic        ov, un, done, inv, div_zero, inexact;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_done = 0;
    logic chk_low = 1'b0;

    fp_mul dut (
        .clk(clk), .rst(rst), .act(act), .in1(in1), .in2(in2),
        .round_m(round_m), .out(out), .ov(ov), .un(un), .done(done),
        .inv(inv), .div_zero(div_zero), .inexact(inexact)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (chk_low) begin
            chk_low = 1'b0;
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL done_width: done=%b required 0", done);
            end
        end
        if (rst && done === 1'b1) begin
            n_done++;
            chk_low = 1'b1;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: out=%h with no pending operation", out);
            end else begin
                e = sb.pop_front();
                total++;
                if (out !== e.res) begin
                    bad++;
                    $display("FAIL result: out=%h required %h", out, e.res);
                end
                total++;
                if ({ov, un, inv, div_zero, inexact} !== e.flags) begin
                    bad++;
                    $display("FAIL flags: got %b required %b (out=%h)",
                             {ov, un, inv, div_zero, inexact}, e.flags, e.res);
                end
                total++;
                if (cyc - e.issue != e.lat) begin
                    bad++;
                    $display("FAIL latency: got %0d required %0d (out=%h)",
                             cyc - e.issue, e.lat, e.res);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         input logic [31:0] eo, input logic [4:0] ef, input int lat);
        exp_t e;
        @(negedge clk);
        in1 = a;
        in2 = b;
        round_m = rm;
        act = 1'b1;
        e.res = eo;
        e.flags = ef;
        e.lat = lat;
        e.issue = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        act = 1'b0;
    endtask

    task automatic wait_empty();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results still pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                       input logic [31:0] eo, input logic [4:0] ef, input int lat);
        issue(a, b, rm, eo, ef, lat);
        wait_empty();
    endtask

    initial begin
        int nd;
        #12;
        total++;
        if ({out, ov, un, done, inv, div_zero, inexact} !== 38'd0) begin
            bad++;
            $display("FAIL reset_state: out=%h flags=%b required 0", out,
                     {ov, un, done, inv, div_zero, inexact});
        end
        @(negedge clk);
        rst = 1'b1;

        // Normal path
        run(32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 5'b00000, 26);
        run(32'h3F800001, 32'h3F800001, RNE, 32'h3F800002, 5'b00001, 26);
        run(32'h3F800001, 32'h3F800001, RU,  32'h3F800003, 5'b00001, 26);
        run(32'h3F800001, 32'h3F800001, RZ,  32'h3F800002, 5'b00001, 26);
        run(32'h3F800001, 32'h3F800001, RNA, 32'h3F800002, 5'b00001, 26);
        run(32'hBF800001, 32'h3F800001, RD,  32'hBF800003, 5'b00001, 26);
        run(32'h7F000000, 32'h7F000000, RNE, 32'h7F800000, 5'b10001, 26);
        run(32'h7F000000, 32'h7F000000, RZ,  32'h7F7FFFFF, 5'b10001, 26);
        run(32'hFF000000, 32'h7F000000, RU,  32'hFF7FFFFF, 5'b10001, 26);
        run(32'hFF000000, 32'h7F000000, RD,  32'hFF800000, 5'b10001, 26);
        run(32'h00800000, 32'h00800000, RNE, 32'h00000000, 5'b01001, 26);

        // Special path
        run(32'h00000000, 32'h7F800000, RNE, 32'h7FC00000, 5'b00100, 1);
        run(32'hFF800000, 32'h40000000, RNE, 32'hFF800000, 5'b00000, 1);
        run(32'h80000000, 32'h3F800000, RNE, 32'h80000000, 5'b00000, 1);
        run(32'h7FC00001, 32'h3F800000, RNE, 32'h7FC00000, 5'b00100, 1);

        // act during MUL is ignored; the first result must be unchanged
        issue(32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 5'b00000, 26);
        repeat (4) @(negedge clk);
        in1 = 32'h40400000;
        in2 = 32'h40A00000;
        round_m = RU;
        act = 1'b1;
        @(negedge clk);
        act = 1'b0;
        wait_empty();
        repeat (30) @(negedge clk);

        // Leave non-zero outputs behind, then reset mid-operation
        run(32'h7FC00001, 32'h3F800000, RNE, 32'h7FC00000, 5'b00100, 1);
        @(negedge clk);
        in1 = 32'h3F800001;
        in2 = 32'h3F800001;
        round_m = RNE;
        act = 1'b1;
        @(negedge clk);
        act = 1'b0;
        nd = n_done;
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({out, ov, un, done, inv, div_zero, inexact} !== 38'd0) begin
            bad++;
            $display("FAIL reset_mid_op: out=%h flags=%b required 0", out,
                     {ov, un, done, inv, div_zero, inexact});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (n_done != nd) begin
            bad++;
            $display("FAIL reset_no_done: %0d done pulses, required 0", n_done - nd);
        end

        // Operation after reset completes normally
        run(32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 5'b00000, 26);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
